// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the cpu decode/execute FSM.
//
// Issues word reads into an instruction bram that has a 1-cycle read latency.
// Each returned word is converted to big-endian, tagged with its byte PC and
// buffered in a small prefetch FIFO. The FIFO head goes to the consumer over a
// valid/ready handshake. A redirect from execute flushes the FIFO and any
// in-flight read, then restarts fetch at the new target.
//
// Ports:
//   clk, n_reset        clock (rising edge), asynchronous active-low reset
//   run                 1 = keep issuing reads, 0 = stop issuing (state IDLE)
//   mem_en, mem_addr    bram read enable and word address
//   mem_rdata           bram read data, valid the cycle after mem_en
//   redirect,
//   redirect_pc         flush and restart fetch at redirect_pc (word aligned)
//   inst_valid,
//   inst_ready          FIFO head handshake
//   inst, inst_pc       head instruction (big-endian) and its byte address
module fetch_unit #(
   parameter int unsigned ADDR_W        = 18,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter bit          LITTLE_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              run,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_C = FIFO_DEPTH[CNT_W:0];
   localparam logic [CNT_W-1:0] FULL_C  = FIFO_DEPTH[CNT_W-1:0];

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        pend_pc_q, pend_pc_d;
   logic               pending_q, pending_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        fifo_inst_q [FIFO_DEPTH];
   logic [31:0]        fifo_inst_d [FIFO_DEPTH];
   logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
   logic [31:0]        fifo_pc_d   [FIFO_DEPTH];

   logic [CNT_W:0]     credit_used;
   logic               has_credit;
   logic               push;
   logic               pop;
   logic               unused_pc_bits;

   function automatic logic [31:0] to_big_endian(input logic [31:0] w);
      if (LITTLE_ENDIAN)
         return {w[7:0], w[15:8], w[23:16], w[31:24]};
      else
         return w;
   endfunction

   // Credit counts the in-flight read as occupied; a same-cycle pop is not
   // credited, which keeps the issue decision independent of inst_ready.
   assign credit_used    = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
   assign has_credit     = credit_used < DEPTH_C;
   assign unused_pc_bits = ^redirect_pc[1:0];

   // State register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic (redirect never changes state)
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run)  state_d = RUN;
         RUN:     if (!run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mem_en = 1'b0;
      if (state_q == RUN && has_credit && !redirect)
         mem_en = 1'b1;
   end

   assign mem_addr   = fetch_pc_q[ADDR_W+1:2];
   assign inst_valid = (count_q != '0);
   assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
   assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

   // A pending response is only pushed if no redirect hit it in flight.
   assign push = pending_q && !redirect;
   assign pop  = inst_valid && inst_ready;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      pend_pc_d   = pend_pc_q;
      pending_d   = mem_en;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      fifo_inst_d = fifo_inst_q;
      fifo_pc_d   = fifo_pc_q;

      if (mem_en) begin
         pend_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         pending_d  = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fifo_inst_d[wr_ptr_q] = to_big_endian(mem_rdata);
            fifo_pc_d[wr_ptr_q]   = pend_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fetch_pc_q <= {RESET_PC[31:2], 2'b00};
         pend_pc_q  <= 32'h0;
         pending_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         pending_q  <= pending_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage carries data only; validity comes from count_q.
   always_ff @(posedge clk) begin
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
   end

   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!n_reset) !(push && count_q == FULL_C)
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned ADDR_W = 18;

   logic              clk = 1'b0;
   logic              n_reset;
   // little-endian instance
   logic              run, redirect, inst_ready;
   logic [31:0]       redirect_pc;
   logic              mem_en, inst_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata, inst, inst_pc;
   // pass-through instance
   logic              run_b, redirect_b, inst_ready_b;
   logic [31:0]       redirect_pc_b;
   logic              mem_en_b, inst_valid_b;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [31:0]       mem_rdata_b, inst_b, inst_pc_b;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pop = 0, n_pop_b = 0;
   int          n_reads = 0, n_reads_b = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_pc_b = 32'h0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .RESET_PC(32'h0), .LITTLE_ENDIAN(1'b1)) u_le (
      .clk(clk), .n_reset(n_reset), .run(run), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .RESET_PC(32'h0), .LITTLE_ENDIAN(1'b0)) u_be (
      .clk(clk), .n_reset(n_reset), .run(run_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
      .mem_rdata(mem_rdata_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .inst_valid(inst_valid_b), .inst_ready(inst_ready_b), .inst(inst_b), .inst_pc(inst_pc_b)
   );

   // Program image in big-endian form: the first three words are the
   // E3A0000n sequence, everything else a hash of the word address.
   function automatic logic [31:0] be_word(input logic [ADDR_W-1:0] a);
      logic [31:0] a32;
      a32 = {{(32-ADDR_W){1'b0}}, a};
      if (a32 < 32'd3) return 32'hE3A0_0001 + a32;
      return (a32 * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // bram models: 1-cycle read latency; little-endian storage for u_le
   always @(posedge clk) begin
      if (mem_en)   mem_rdata   <= swap32(be_word(mem_addr));
      if (mem_en_b) mem_rdata_b <= be_word(mem_addr_b);
   end

   // One clock cycle: sample mid-cycle, score any accepted instruction
   // against the expected in-order PC stream, then move past the edge.
   task automatic tick();
      logic [31:0] want;
      @(negedge clk);
      if (mem_en)   n_reads++;
      if (mem_en_b) n_reads_b++;
      if (inst_valid && inst_ready) begin
         want = be_word(exp_pc[ADDR_W+1:2]);
         n_checks++;
         if (inst_pc !== exp_pc || inst !== want) begin
            n_errors++;
            $display("FAIL stream_le: got pc=%h inst=%h, expected pc=%h inst=%h", inst_pc, inst, exp_pc, want);
         end
         exp_pc = exp_pc + 32'd4;
         n_pop++;
      end
      if (inst_valid_b && inst_ready_b) begin
         want = be_word(exp_pc_b[ADDR_W+1:2]);
         n_checks++;
         if (inst_pc_b !== exp_pc_b || inst_b !== want) begin
            n_errors++;
            $display("FAIL stream_be: got pc=%h inst=%h, expected pc=%h inst=%h", inst_pc_b, inst_b, exp_pc_b, want);
         end
         exp_pc_b = exp_pc_b + 32'd4;
         n_pop_b++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      run = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      run_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0; inst_ready_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %b, expected 0", mem_en); end
      n_checks++;
      if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_inst_valid: got %b, expected 0", inst_valid); end
      n_checks++;
      if (inst !== 32'h0 || inst_pc !== 32'h0) begin
         n_errors++; $display("FAIL reset_inst: got inst=%h pc=%h, expected 0/0", inst, inst_pc);
      end
      n_checks++;
      if (mem_addr !== '0) begin n_errors++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
      n_reset = 1'b1;
      tick();
   endtask

   task automatic test_first_fetch();
      int pops0;
      inst_ready = 1'b1; run = 1'b1; exp_pc = 32'h0;
      tick(); // enter RUN
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== '0) begin
         n_errors++; $display("FAIL t1_first_issue: got mem_en=%b addr=%h, expected 1/0", mem_en, mem_addr);
      end
      n_checks++;
      if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL t1_valid_early0: got %b, expected 0", inst_valid); end
      tick();
      n_checks++;
      if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL t1_valid_early1: got %b, expected 0", inst_valid); end
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== 32'hE3A0_0001 || inst_pc !== 32'h0) begin
         n_errors++;
         $display("FAIL t1_first_inst: got v=%b inst=%h pc=%h, expected 1/E3A00001/0", inst_valid, inst, inst_pc);
      end
      pops0 = n_pop;
      repeat (10) tick();
      n_checks++;
      if (n_pop - pops0 != 10) begin n_errors++; $display("FAIL t1_throughput: got %0d pops, expected 10", n_pop - pops0); end
   endtask

   task automatic test_backpressure();
      int reads0, pops0;
      inst_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0; exp_pc = 32'h0;
      reads0 = n_reads;
      repeat (10) tick();
      n_checks++;
      if (n_reads - reads0 != 4) begin n_errors++; $display("FAIL t2_reads: got %0d, expected 4", n_reads - reads0); end
      n_checks++;
      if (mem_en !== 1'b0) begin n_errors++; $display("FAIL t2_mem_en_full: got %b, expected 0", mem_en); end
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hE3A0_0001) begin
         n_errors++; $display("FAIL t2_head_held: got v=%b pc=%h inst=%h, expected 1/0/E3A00001", inst_valid, inst_pc, inst);
      end
      inst_ready = 1'b1;
      pops0 = n_pop;
      repeat (8) tick();
      n_checks++;
      if (n_pop - pops0 < 5) begin n_errors++; $display("FAIL t2_release: got %0d pops, expected >= 5", n_pop - pops0); end
   endtask

   task automatic test_redirect();
      inst_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0; exp_pc = 32'h0;
      repeat (4) tick(); // 3 entries buffered, 4th read in flight
      n_checks++;
      if (inst_valid !== 1'b1 || mem_en !== 1'b0) begin
         n_errors++; $display("FAIL t3_setup: got v=%b mem_en=%b, expected 1/0", inst_valid, mem_en);
      end
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0; exp_pc = 32'h0000_0100;
      #1;
      n_checks++;
      if (mem_en !== 1'b1 || mem_addr !== 18'h40) begin
         n_errors++; $display("FAIL t3_target_addr: got mem_en=%b addr=%h, expected 1/40", mem_en, mem_addr);
      end
      n_checks++;
      if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL t3_flushed: got %b, expected 0", inst_valid); end
      inst_ready = 1'b1;
      tick();
      n_checks++;
      if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL t3_valid_early: got %b, expected 0", inst_valid); end
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0100) begin
         n_errors++; $display("FAIL t3_first_target: got v=%b pc=%h, expected 1/00000100", inst_valid, inst_pc);
      end
      repeat (4) tick();
   endtask

   task automatic test_wrap();
      int pops0;
      inst_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0; exp_pc = 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (mem_addr !== 18'h3FFFF) begin n_errors++; $display("FAIL t4_top_addr: got %h, expected 3ffff", mem_addr); end
      pops0 = n_pop;
      tick();
      n_checks++;
      if (mem_addr !== 18'h0) begin n_errors++; $display("FAIL t4_addr_wrap: got %h, expected 0", mem_addr); end
      repeat (4) tick();
      n_checks++;
      if (n_pop - pops0 < 2) begin n_errors++; $display("FAIL t4_wrap_pops: got %0d, expected >= 2", n_pop - pops0); end
   endtask

   task automatic test_random_stream();
      logic [31:0] tgt;
      int pops0;
      pops0 = n_pop;
      for (int i = 0; i < 300; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            tgt = $urandom;
            redirect = 1'b1; redirect_pc = tgt;
            tick();
            redirect = 1'b0; exp_pc = {tgt[31:2], 2'b00};
         end else begin
            tick();
         end
      end
      n_checks++;
      if (n_pop - pops0 < 100) begin n_errors++; $display("FAIL rand_progress: got %0d pops, expected >= 100", n_pop - pops0); end
      inst_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      repeat (3) tick(); // steady stream, a read is pending
      n_reset = 1'b0;
      #1;
      n_checks++;
      if (inst_valid !== 1'b0 || mem_en !== 1'b0) begin
         n_errors++; $display("FAIL t5_immediate: got v=%b mem_en=%b, expected 0/0", inst_valid, mem_en);
      end
      exp_pc = 32'h0;
      tick();
      n_reset = 1'b1;
      tick(); // enter RUN
      tick(); // first read returns
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         n_errors++; $display("FAIL t5_restart: got v=%b pc=%h, expected 1/0", inst_valid, inst_pc);
      end
      repeat (3) tick();
   endtask

   task automatic test_big_endian_run_toggle();
      int pops0, reads0;
      inst_ready_b = 1'b1; run_b = 1'b1; exp_pc_b = 32'h0;
      pops0 = n_pop_b;
      repeat (8) tick();
      n_checks++;
      if (n_pop_b - pops0 < 5) begin n_errors++; $display("FAIL t6_pops: got %0d, expected >= 5", n_pop_b - pops0); end
      run_b = 1'b0;
      tick(); // back to IDLE; the last read still completes
      reads0 = n_reads_b;
      repeat (5) tick();
      n_checks++;
      if (n_reads_b != reads0) begin n_errors++; $display("FAIL t6_idle_reads: got %0d, expected 0", n_reads_b - reads0); end
      n_checks++;
      if (inst_valid_b !== 1'b0) begin n_errors++; $display("FAIL t6_drained: got %b, expected 0", inst_valid_b); end
      run_b = 1'b1;
      pops0 = n_pop_b;
      repeat (8) tick();
      n_checks++;
      if (n_pop_b - pops0 < 5) begin n_errors++; $display("FAIL t6_resume: got %0d pops, expected >= 5", n_pop_b - pops0); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_random_stream();
      test_async_reset();
      test_big_endian_run_toggle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
